// File: rtl/column_pkg.sv
// Shared definitions for the LED column sequencer: board column count,
// clock-derived drive limits and the sequencer state encoding.
package column_pkg;

  localparam int unsigned NB_COLUMNS   = 8;
  localparam int unsigned COL_W        = $clog2(NB_COLUMNS);
  localparam int unsigned CLK_FREQ_HZ  = 66_000_000;
  localparam int unsigned MAX_DRIVE_US = 10;

  // Converts a duration in whole microseconds to clk cycles.
  function automatic int unsigned us_to_cycles(input int unsigned us);
    return (CLK_FREQ_HZ / 1_000_000) * us;
  endfunction

  // LED overdrive limit expressed in clk cycles (660 at 66 MHz).
  localparam int unsigned MAX_DRIVE_CYCLES = us_to_cycles(MAX_DRIVE_US);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_LATCH     = 3'd2,
    ST_BLANK     = 3'd3,
    ST_DRIVE     = 3'd4,
    ST_WAIT_DATA = 3'd5
  } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a terminal-count flag.
// Ports:
//   clk, nrst    clock and async active-low reset
//   i_load       load i_load_val this cycle (takes priority over counting)
//   i_load_val   start value; the timer spans i_load_val+1 cycles
//   o_done_c     combinational, high while the count is zero
module cycle_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done_c
);

  logic [WIDTH-1:0] r_count;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done_c = (r_count == '0);

endmodule

// File: rtl/column_sequencer.sv
// Schedules one display slice across the LED columns: requests column data
// from the loader, latches it into the driver, blanks all columns, then
// drives a single column for a bounded time while prefetching the next one.
// Ports:
//   clk, nrst    66 MHz clock, async active-low reset
//   enable       sequencer allowed to run; low forces IDLE
//   slice_start  1-cycle pulse starting a new angular slice
//   data_ready   1-cycle loader ack for the column on load_col
//   clr_err      clears the sticky overrun flag
//   load_req     level request to the loader, load_col stable while high
//   load_col     column index being requested
//   latch        1-cycle driver LAT pulse
//   mux_out      one-hot column enable, decoded from state and column
//   slice_done   1-cycle pulse after the last column's drive
//   overrun      sticky: slice_start seen while busy
module column_sequencer
  import column_pkg::*;
#(
  parameter int unsigned DRIVE_CYCLES = MAX_DRIVE_CYCLES,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       slice_start,
  input  logic       data_ready,
  input  logic       clr_err,
  output logic       load_req,
  output logic [2:0] load_col,
  output logic       latch,
  output logic [7:0] mux_out,
  output logic       slice_done,
  output logic       overrun
);

  localparam int unsigned DRV_W = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned TW    = (DRV_W > BLK_W) ? DRV_W : BLK_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NB_COLUMNS - 1);

  // Reject parameter values that would exceed the LED limit or stall.
  if (DRIVE_CYCLES > MAX_DRIVE_CYCLES || DRIVE_CYCLES < 1) begin : g_bad_drive
    $error("column_sequencer: DRIVE_CYCLES out of range");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("column_sequencer: BLANK_CYCLES must be at least 1");
  end

  state_t            r_state;
  state_t            w_next;
  logic [COL_W-1:0]  r_col;
  logic              r_pending;
  logic              r_load_req;
  logic [COL_W-1:0]  r_load_col;
  logic              r_latch;
  logic              r_slice_done;
  logic              r_overrun;

  logic [COL_W-1:0]  w_col_nxt;
  logic              w_pending_nxt;
  logic              w_load_req_nxt;
  logic [COL_W-1:0]  w_load_col_nxt;
  logic              w_latch_nxt;
  logic              w_slice_done_nxt;
  logic              w_overrun_nxt;
  logic              w_tmr_load;
  logic [TW-1:0]     w_tmr_val;
  logic              w_tmr_done;
  logic              w_ack;
  logic              w_pending_eff;
  logic              w_last_col;
  logic [7:0]        w_mux;

  // An ack only counts while a request is actually outstanding.
  assign w_ack         = data_ready & r_load_req;
  // An ack on the final drive cycle is honoured as if it came earlier.
  assign w_pending_eff = r_pending | w_ack;
  assign w_last_col    = (r_col == LAST_COL);

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .nrst       (nrst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done_c   (w_tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (slice_start) w_next = ST_REQ;
        ST_REQ:       if (w_ack) w_next = ST_LATCH;
        ST_LATCH:     w_next = ST_BLANK;
        ST_BLANK:     if (w_tmr_done) w_next = ST_DRIVE;
        ST_DRIVE: begin
          if (w_tmr_done) begin
            if (w_last_col) begin
              w_next = ST_IDLE;
            end else if (w_pending_eff) begin
              w_next = ST_LATCH;
            end else begin
              w_next = ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: if (w_ack) w_next = ST_LATCH;
        default:      w_next = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values, registered below.
  always_comb begin
    w_col_nxt        = r_col;
    w_pending_nxt    = r_pending;
    w_load_req_nxt   = r_load_req;
    w_load_col_nxt   = r_load_col;
    w_latch_nxt      = 1'b0;
    w_slice_done_nxt = 1'b0;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;

    // Set wins over clear when both land in the same cycle.
    w_overrun_nxt = r_overrun;
    if (clr_err) w_overrun_nxt = 1'b0;
    if (slice_start && (r_state != ST_IDLE)) w_overrun_nxt = 1'b1;

    if (!enable) begin
      w_col_nxt      = '0;
      w_pending_nxt  = 1'b0;
      w_load_req_nxt = 1'b0;
      w_load_col_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (slice_start) begin
            w_col_nxt      = '0;
            w_load_col_nxt = '0;
            w_load_req_nxt = 1'b1;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            w_load_req_nxt = 1'b0;
            w_latch_nxt    = 1'b1;
          end
        end
        ST_LATCH: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(BLANK_CYCLES - 1);
        end
        ST_BLANK: begin
          if (w_tmr_done) begin
            w_tmr_load    = 1'b1;
            w_tmr_val     = TW'(DRIVE_CYCLES - 1);
            w_pending_nxt = 1'b0;
            // Prefetch the next column while this one is driven.
            if (!w_last_col) begin
              w_load_req_nxt = 1'b1;
              w_load_col_nxt = r_col + COL_W'(1);
            end
          end
        end
        ST_DRIVE: begin
          if (w_ack) begin
            w_pending_nxt  = 1'b1;
            w_load_req_nxt = 1'b0;
          end
          if (w_tmr_done) begin
            if (w_last_col) begin
              w_slice_done_nxt = 1'b1;
              w_col_nxt        = '0;
              w_load_col_nxt   = '0;
              w_load_req_nxt   = 1'b0;
              w_pending_nxt    = 1'b0;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
              if (w_pending_eff) begin
                w_latch_nxt    = 1'b1;
                w_pending_nxt  = 1'b0;
                w_load_req_nxt = 1'b0;
              end
            end
          end
        end
        ST_WAIT_DATA: begin
          if (w_ack) begin
            w_load_req_nxt = 1'b0;
            w_latch_nxt    = 1'b1;
          end
        end
        default: begin
          w_col_nxt      = '0;
          w_pending_nxt  = 1'b0;
          w_load_req_nxt = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_col        <= '0;
      r_pending    <= 1'b0;
      r_load_req   <= 1'b0;
      r_load_col   <= '0;
      r_latch      <= 1'b0;
      r_slice_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_col        <= w_col_nxt;
      r_pending    <= w_pending_nxt;
      r_load_req   <= w_load_req_nxt;
      r_load_col   <= w_load_col_nxt;
      r_latch      <= w_latch_nxt;
      r_slice_done <= w_slice_done_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // Column enable is gated by reset so the LEDs go dark immediately.
  assign w_mux = (nrst && (r_state == ST_DRIVE)) ? (NB_COLUMNS'(1) << r_col) : '0;

  assign mux_out    = w_mux;
  assign load_req   = r_load_req;
  assign load_col   = r_load_col;
  assign latch      = r_latch;
  assign slice_done = r_slice_done;
  assign overrun    = r_overrun;

endmodule

// File: doc/column_sequencer.md
Name: column_sequencer

Overview:
- Schedules one display slice across the 8 LED columns: fetches column data into the LED driver, latches it, applies an anti-ghosting blank, then drives exactly one column for a bounded time.
- Sits between the rotation/slice-position logic, the framebuffer-to-driver loader and the column mux transistors.
- Prefetches column k+1 while column k is driven.
- Enforces the LED overdrive limit: at most 10 µs on-time per column.

Parameters:
- DRIVE_CYCLES, 660, on-time per column in clk cycles (66 MHz; 660 = 10 µs); elaboration error if >660 or <1.
- BLANK_CYCLES, 16, all-columns-off gap after each latch; elaboration error if <1.
- NB_COLUMNS, 8, columns per slice; fixed by the board.

Ports:
- clk  in  1  system clock, 66 MHz.
- nrst  in  1  asynchronous, active-low reset.
- enable  in  1  sequencer allowed to run.
- slice_start  in  1  1-cycle pulse: new angular slice begins.
- data_ready  in  1  1-cycle ack from the loader: column load_col shifted into the driver.
- clr_err  in  1  clears overrun.
- load_req  out  1  level request for the loader to shift column load_col.
- load_col  out  3  column index requested; stable while load_req=1.
- latch  out  1  1-cycle driver latch (LAT) pulse.
- mux_out  out  8  one-hot column enable; 0 when no column is on.
- slice_done  out  1  1-cycle pulse after the last column's drive ends.
- overrun  out  1  sticky: slice_start arrived while not IDLE.

Behaviour:
- Reset (async, nrst=0): state=IDLE. All outputs 0, col=0, counters 0, the pending-data flag cleared. mux_out is forced 0 combinationally while nrst=0.
- All outputs are registered except mux_out, which is decoded from state and col.
- States: IDLE, REQ, LATCH, BLANK, DRIVE, WAIT_DATA.
- IDLE:
  - mux_out=0.
  - slice_start & enable → REQ with col=0, load_col=0, load_req=1 on the next cycle.
- REQ:
  - Holds load_req=1.
  - data_ready sampled high → LATCH; load_req=0 from that edge.
- LATCH:
  - latch=1 for exactly 1 cycle, mux_out=0.
  - Then → BLANK.
- BLANK:
  - mux_out=0 for BLANK_CYCLES cycles.
  - Then → DRIVE.
- DRIVE:
  - mux_out = 1<<col for exactly DRIVE_CYCLES cycles.
  - On the first DRIVE cycle, if col<7: load_req=1, load_col=col+1 (prefetch).
  - A data_ready during DRIVE sets the pending flag and drops load_req.
  - On the last cycle, col==7 → IDLE, slice_done=1 next cycle, col←0.
  - On the last cycle, col<7 with pending set → LATCH, col←col+1, pending cleared.
  - On the last cycle, col<7 with pending clear → WAIT_DATA, col←col+1.
- WAIT_DATA:
  - mux_out=0, load_req stays 1.
  - data_ready → LATCH.
- The driver latch never occurs while any column is on: LATCH always has mux_out=0.
- Timing:
  - Drive counter width is $clog2(DRIVE_CYCLES); it reloads on each DRIVE entry.
  - DRIVE is never extended, even when data is late.
- data_ready when load_req=0 is ignored. data_ready arriving on the same cycle load_req rises is not possible, because load_req is registered.
- slice_start when not IDLE:
  - Ignored for sequencing; overrun←1.
  - overrun clears only on clr_err. If clr_err and a new overrun occur in the same cycle, set wins.
- enable low in any state:
  - Next cycle state=IDLE, load_req=0, mux_out=0, col=0, pending cleared.
  - No slice_done is issued.
- Column wrap: col is 0..7 and never exceeds 7; it resets to 0 at IDLE.

Decomposition:
- column_pkg holds:
  - the state enum;
  - NB_COLUMNS=8;
  - MAX_DRIVE_CYCLES=660;
  - the clk frequency constant, used for µs→cycles conversion.
- One sub-module, cycle_timer: a loadable down-counter with a done flag, shared by BLANK and DRIVE, width parameterised.

Test Plan:
- Slice with data_ready tied to 1, defaults, slice_start at cycle 0:
  - load_req=1 at cycle 1;
  - latch at cycle 2;
  - mux_out=0 for cycles 3–18;
  - mux_out=0x01 for cycles 19–678;
  - latch again at cycle 679;
  - eight one-hot values 0x01…0x80, each exactly 660 cycles, with 17 off cycles between them;
  - slice_done at cycle 5418.
- Late data: hold data_ready low until 100 cycles after column 2's drive ends → WAIT_DATA with mux_out=0 for 100 cycles, then latch, 16 blank cycles, and a 660-cycle 0x08 drive.
- Overrun: slice_start pulsed during column 3's DRIVE → overrun=1 and the sequence is unaffected. clr_err then gives overrun=0; clr_err together with a new slice_start gives overrun=1.
- Enable drop at column 5's DRIVE cycle 300 → next cycle mux_out=0, load_req=0, state IDLE, no slice_done. A later slice_start with enable=1 restarts at column 0.
- Async reset asserted mid-DRIVE (asynchronous to clk): mux_out=0 immediately; after release, all outputs are 0 and the block waits in IDLE.
- Spurious data_ready while IDLE and during BLANK → ignored: no latch, and the pending flag does not cause an early latch.
